// File: rtl/bird_motion_pkg.sv
// Shared game constants: state encoding, screen geometry and default bird physics.
// Imported by the motion, pipe/collision and render blocks.
package bird_motion_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAYING = 2'd1,
        ST_DEAD    = 2'd2
    } game_state_e;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam int PW         = 9;
    localparam int VW         = 5;
    localparam int Y_START    = 200;
    localparam int Y_FLOOR    = 440;
    localparam int GRAV       = 1;
    localparam int FLAP_SPEED = 6;
    localparam int V_MAX      = 7;

endpackage

// File: rtl/bird_motion_if.sv
// Bundle between the bird motion block and its neighbours: frame tick and sampler
// buttons in, bird position, game state and sampler enable out.
interface bird_motion_if #(
    parameter int PW = bird_motion_pkg::PW
) ();

    logic          frame_tick_i;
    logic          inp_valid_i;
    logic          flap_i;
    logic          start_i;
    logic          collide_i;
    logic          inp_en_o;
    logic [PW-1:0] bird_y_o;
    logic [1:0]    state_o;
    logic          game_over_o;

    modport slave (
        input  frame_tick_i, inp_valid_i, flap_i, start_i, collide_i,
        output inp_en_o, bird_y_o, state_o, game_over_o
    );

    modport master (
        output frame_tick_i, inp_valid_i, flap_i, start_i, collide_i,
        input  inp_en_o, bird_y_o, state_o, game_over_o
    );

endinterface

// File: rtl/bird_integrator.sv
// One physics step for the bird: next velocity (flap or saturating gravity) and
// next row, clamped at the ceiling and flagged when it reaches the floor.
module bird_integrator #(
    parameter int PW         = bird_motion_pkg::PW,
    parameter int VW         = bird_motion_pkg::VW,
    parameter int Y_FLOOR    = bird_motion_pkg::Y_FLOOR,
    parameter int GRAV       = bird_motion_pkg::GRAV,
    parameter int FLAP_SPEED = bird_motion_pkg::FLAP_SPEED,
    parameter int V_MAX      = bird_motion_pkg::V_MAX
) (
    input  logic [PW-1:0]        y_i,
    input  logic signed [VW-1:0] vel_i,
    input  logic                 flap_i,
    output logic [PW-1:0]        y_o,
    output logic signed [VW-1:0] vel_o,
    output logic                 floor_o
);

    // Two extra bits: one for the sign, one so y + vel cannot wrap.
    localparam int SW = PW + 2;

    logic signed [VW:0]   vel_inc;
    logic signed [VW-1:0] vel_sel;
    logic signed [SW-1:0] y_sum;
    logic                 ceil_hit;

    always_comb begin
        vel_inc = {vel_i[VW-1], vel_i} + (VW+1)'(GRAV);

        if (flap_i) begin
            vel_sel = VW'(-FLAP_SPEED);
        end else if (vel_inc > (VW+1)'(V_MAX)) begin
            vel_sel = VW'(V_MAX);
        end else begin
            vel_sel = vel_inc[VW-1:0];
        end

        y_sum    = {2'b00, y_i} + {{(SW-VW){vel_sel[VW-1]}}, vel_sel};
        ceil_hit = y_sum[SW-1];
        floor_o  = !ceil_hit && (y_sum >= SW'(Y_FLOOR));

        if (ceil_hit) begin
            y_o   = '0;
            vel_o = '0;
        end else if (floor_o) begin
            y_o   = PW'(Y_FLOOR);
            vel_o = vel_sel;
        end else begin
            y_o   = y_sum[PW-1:0];
            vel_o = vel_sel;
        end
    end

endmodule

// File: rtl/bird_motion.sv
// Game-state FSM and bird position/velocity registers; one physics step per
// frame tick while playing, game-over pulse on entering DEAD.
module bird_motion #(
    parameter int PW         = bird_motion_pkg::PW,
    parameter int VW         = bird_motion_pkg::VW,
    parameter int Y_START    = bird_motion_pkg::Y_START,
    parameter int Y_FLOOR    = bird_motion_pkg::Y_FLOOR,
    parameter int GRAV       = bird_motion_pkg::GRAV,
    parameter int FLAP_SPEED = bird_motion_pkg::FLAP_SPEED,
    parameter int V_MAX      = bird_motion_pkg::V_MAX
) (
    input logic           clk_i,
    input logic           rst_ni,
    bird_motion_if.slave  bus
);

    import bird_motion_pkg::*;

    game_state_e          state_q, state_d;
    logic [PW-1:0]        y_q, y_d;
    logic signed [VW-1:0] vel_q, vel_d;
    logic                 flap_pending_q, flap_pending_d;
    logic                 game_over_q, game_over_d;
    logic                 inp_en_q, inp_en_d;

    logic                 flap_ok;
    logic                 start_ok;
    logic [PW-1:0]        y_step;
    logic signed [VW-1:0] vel_step;
    logic                 floor_hit;

    assign flap_ok  = bus.inp_valid_i & bus.flap_i;
    assign start_ok = bus.inp_valid_i & bus.start_i;

    // A flap landing on the tick cycle itself counts for that tick.
    bird_integrator #(
        .PW         (PW),
        .VW         (VW),
        .Y_FLOOR    (Y_FLOOR),
        .GRAV       (GRAV),
        .FLAP_SPEED (FLAP_SPEED),
        .V_MAX      (V_MAX)
    ) u_integrator (
        .y_i     (y_q),
        .vel_i   (vel_q),
        .flap_i  (flap_pending_q | flap_ok),
        .y_o     (y_step),
        .vel_o   (vel_step),
        .floor_o (floor_hit)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d        = state_q;
        y_d            = y_q;
        vel_d          = vel_q;
        flap_pending_d = flap_pending_q;
        game_over_d    = 1'b0;
        inp_en_d       = !bus.frame_tick_i;

        unique case (state_q)
            ST_IDLE: begin
                y_d            = PW'(Y_START);
                vel_d          = '0;
                flap_pending_d = 1'b0;
                if (start_ok) state_d = ST_PLAYING;
            end
            ST_PLAYING: begin
                // Collision wins over a simultaneous step: the bird dies where it is.
                if (bus.collide_i) begin
                    state_d        = ST_DEAD;
                    game_over_d    = 1'b1;
                    flap_pending_d = 1'b0;
                end else if (bus.frame_tick_i) begin
                    y_d            = y_step;
                    vel_d          = vel_step;
                    flap_pending_d = 1'b0;
                    if (floor_hit) begin
                        state_d     = ST_DEAD;
                        game_over_d = 1'b1;
                    end
                end else if (flap_ok) begin
                    flap_pending_d = 1'b1;
                end
            end
            ST_DEAD: begin
                if (start_ok) begin
                    state_d        = ST_IDLE;
                    y_d            = PW'(Y_START);
                    vel_d          = '0;
                    flap_pending_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            y_q            <= PW'(Y_START);
            vel_q          <= '0;
            flap_pending_q <= 1'b0;
            game_over_q    <= 1'b0;
            inp_en_q       <= 1'b1;
        end else begin
            state_q        <= state_d;
            y_q            <= y_d;
            vel_q          <= vel_d;
            flap_pending_q <= flap_pending_d;
            game_over_q    <= game_over_d;
            inp_en_q       <= inp_en_d;
        end
    end

    assign bus.inp_en_o    = inp_en_q;
    assign bus.bird_y_o    = y_q;
    assign bus.state_o     = state_q;
    assign bus.game_over_o = game_over_q;

endmodule
